// File: rtl/riscv_crypto_fu_aes_mix_seq.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_crypto_fu_aes_mix_seq
//  Purpose  : Byte-serial AES MixColumns / InvMixColumns functional unit for
//             the RV64 aes64im-style operation. Both 32-bit columns of rs1
//             are transformed independently, one output byte per BUSY cycle,
//             through a single shared GF(2^8) byte datapath.
//  Ports    : g_clk   - clock, rising edge
//             g_reset - asynchronous active-high reset
//             valid   - request valid (sampled in IDLE only)
//             op_dec  - 1 = inverse MixColumns, 0 = forward MixColumns
//             rs1     - 64-bit source, column 0 = [31:0], column 1 = [63:32]
//             flush   - synchronous abort, returns to IDLE on next edge
//             ready   - one-cycle pulse, rd valid while high
//             rd      - 64-bit result
//  Revision : 1.0  initial release
// ============================================================================
module riscv_crypto_fu_aes_mix_seq (
    input  logic        g_clk,
    input  logic        g_reset,
    input  logic        valid,
    input  logic        op_dec,
    input  logic [63:0] rs1,
    input  logic        flush,
    output logic        ready,
    output logic [63:0] rd
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_cnt;
    logic [63:0] r_src;
    logic        r_dec;
    logic [63:0] r_rd;

    logic        w_start;
    logic        w_busy_step;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic; flush dominates everything, including a new request.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_busy_step = 1'b0;
        if (flush) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (valid) begin
                        w_start     = 1'b1;
                        w_state_nxt = ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    w_busy_step = 1'b1;
                    if (r_cnt == 3'd7) begin
                        w_state_nxt = ST_DONE;
                    end
                end
                ST_DONE: begin
                    // Deliberately ignores valid: a held request restarts
                    // only once the unit is back in IDLE.
                    w_state_nxt = ST_IDLE;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Byte datapath. The active column is rotated so that b[0] = a[j],
    // b[1] = a[j+1], ... which turns every output byte into the same fixed
    // coefficient pattern and lets one byte datapath serve all eight bytes.
    // ------------------------------------------------------------------------
    function automatic logic [7:0] xtime(input logic [7:0] b);
        xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    logic [31:0] w_col;
    logic [63:0] w_col_dbl;
    logic [31:0] w_rot;
    logic [7:0]  w_b  [4];
    logic [7:0]  w_x2 [4];
    logic [7:0]  w_x4 [4];
    logic [7:0]  w_x8 [4];
    logic [7:0]  w_fwd;
    logic [7:0]  w_inv;
    logic [7:0]  w_byte;

    assign w_col     = r_cnt[2] ? r_src[63:32] : r_src[31:0];
    assign w_col_dbl = {w_col, w_col} >> {r_cnt[1:0], 3'b000};
    assign w_rot     = w_col_dbl[31:0];

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            w_b[k]  = w_rot[8*k +: 8];
            w_x2[k] = xtime(w_b[k]);
            w_x4[k] = xtime(w_x2[k]);
            w_x8[k] = xtime(w_x4[k]);
        end
    end

    // forward : 02*b0 ^ 03*b1 ^ 01*b2 ^ 01*b3
    assign w_fwd  = w_x2[0] ^ w_x2[1] ^ w_b[1] ^ w_b[2] ^ w_b[3];
    // inverse : 0e*b0 ^ 0b*b1 ^ 0d*b2 ^ 09*b3
    assign w_inv  = (w_x8[0] ^ w_x4[0] ^ w_x2[0])
                  ^ (w_x8[1] ^ w_x2[1] ^ w_b[1])
                  ^ (w_x8[2] ^ w_x4[2] ^ w_b[2])
                  ^ (w_x8[3] ^ w_b[3]);
    assign w_byte = r_dec ? w_inv : w_fwd;

    // ------------------------------------------------------------------------
    // Operand capture, byte counter and result register
    // ------------------------------------------------------------------------
    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            r_cnt <= 3'd0;
            r_src <= 64'h0;
            r_dec <= 1'b0;
            r_rd  <= 64'h0;
        end else begin
            if (w_start) begin
                r_src <= rs1;
                r_dec <= op_dec;
                r_cnt <= 3'd0;
            end else if (w_busy_step) begin
                r_rd[{r_cnt, 3'b000} +: 8] <= w_byte;
                r_cnt                      <= r_cnt + 3'd1;
            end else if (flush) begin
                r_cnt <= 3'd0;
            end
        end
    end

    assign ready = (r_state == ST_DONE);
    assign rd    = r_rd;

endmodule
`default_nettype wire

// File: doc/riscv_crypto_fu_aes_mix_seq.md
RISCV_CRYPTO_FU_AES_MIX_SEQ -- requirements
Module: riscv_crypto_fu_aes_mix_seq

Interface
REQ-001 SHALL have port g_clk  input  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have port g_reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port valid  input  1  request valid; held high by requester until ready.
REQ-004 SHALL have port op_dec  input  1  1 = inverse MixColumns (aes64im), 0 = forward MixColumns.
REQ-005 SHALL have port rs1  input  64  source operand: column 0 = rs1[31:0], column 1 = rs1[63:32].
REQ-006 SHALL have port flush  input  1  synchronous abort of any in-flight operation.
REQ-007 SHALL have port ready  output  1  one-cycle pulse, rd valid while high.
REQ-008 SHALL have port rd  output  64  result, both columns transformed independently.

Function
REQ-009 SHALL be byte-serial: one output byte per BUSY cycle, using one shared GF(2^8) byte datapath, with no full 32-bit column datapath instantiated.
REQ-010 SHALL use the column byte order a0 = col[7:0], a1 = col[15:8], a2 = col[23:16], a3 = col[31:24].
REQ-011 SHALL compute forward output byte j (indices mod 4) as 02*a[j] ^ 03*a[j+1] ^ a[j+2] ^ a[j+3].
REQ-012 SHALL compute inverse output byte j (indices mod 4) as 0e*a[j] ^ 0b*a[j+1] ^ 0d*a[j+2] ^ 09*a[j+3].
REQ-013 SHALL perform GF(2^8) multiplication modulo x^8+x^4+x^3+x+1 (xtime reduction constant 8'h1b).
REQ-014 SHALL implement the states IDLE, BUSY and DONE with a 3-bit byte counter cnt.
REQ-015 SHALL, in IDLE with valid=1 and flush=0, register rs1 and op_dec, clear cnt to 0, and enter BUSY.
REQ-016 SHALL, in BUSY, write result byte cnt: column cnt[2], byte j = cnt[1:0], rd bits [8*cnt+7 : 8*cnt].
REQ-017 SHALL increment cnt each BUSY cycle and move from BUSY to DONE after the cycle in which cnt = 7 is processed.
REQ-018 SHALL assert ready only in DONE, and SHALL return from DONE to IDLE unconditionally after one cycle.
REQ-019 SHALL have a latency such that, if valid is first high in IDLE at cycle T, BUSY occupies T+1..T+8 and ready=1 at T+9.
REQ-020 SHALL NOT start a new operation in the DONE cycle; a valid held high at T+10 starts a new operation.
REQ-021 SHALL ignore valid and rs1 changes during BUSY, since operands are taken from the registered copy; a valid deassertion mid-operation does not abort it.
REQ-022 SHALL, when flush=1 in any state, enter IDLE at the next edge, with ready low in that next cycle; flush has priority over valid in IDLE.
REQ-023 SHALL hold rd stable from DONE until the next operation's first BUSY write; partially written rd after a flush is don't-care.

Reset
REQ-024 SHALL, while g_reset=1, immediately force the state to IDLE, cnt to 0, ready to 0 and rd to 64'h0, independent of g_clk.
REQ-025 SHALL discard an in-flight operation when reset is asserted mid-operation, with no ready pulse afterwards.
REQ-026 SHALL, after reset deassertion, accept valid on the first rising edge.

Verification
REQ-027 SHALL be covered by a forward test: op_dec=0, rs1=64'h5c220af2_455313db -> ready at T+9, rd=64'h9d58dc9f_bca14d8e.
REQ-028 SHALL be covered by an inverse test: op_dec=1, rs1=64'h9d58dc9f_bca14d8e -> ready at T+9, rd=64'h5c220af2_455313db.
REQ-029 SHALL be covered by fixed-point tests: rs1=64'hc6c6c6c6_01010101 in both modes -> rd unchanged; rs1=0 -> rd=0.
REQ-030 SHALL be covered by a flush test: flush=1 at T+4 -> IDLE at T+5, no ready pulse; a new valid at T+6 then completes correctly at T+15.
REQ-031 SHALL be covered by a mid-operation reset test: g_reset pulse at T+3 -> ready and rd immediately 0, no ready pulse afterwards.
REQ-032 SHALL be covered by a back-to-back test: valid held high through DONE -> second operation ready at T+19 with correct rd; compare randomized rs1 against a reference model for 10k operations in both modes.
